fetch_sequencer: RTL and testbench

Instruction-fetch controller that owns the architectural PC and sequences it through the instruction-memory port. It issues one fetch at a time over a req/gnt/rvalid handshake and hands fetched instructions to decode over a valid/ready buffer. It also computes and applies branch/jump redirects from execute, discarding in-flight fetches on the wrong path. It sits between instruction memory and the decode stage and replaces the free-running `pc + 4` update with a stall- and redirect-aware sequencer.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/next_pc_calc.sv | 25 ++
 rtl/fetch_sequencer.sv | 122 ++++++++++++
 tb/tb_fetch_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DROP
    } fetch_state_t;

    localparam int unsigned INSTR_BYTES      = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Sign-extended 16-bit word offset converted to a byte offset.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Redirect decision and branch/jump target computation for the execute-stage instruction.
module next_pc_calc
    import fetch_pkg::*;
(
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_instr,
    input  logic        branch_sel,
    input  logic        zero,
    input  logic        jump_sel,
    input  logic        ex_valid,
    output logic        take,
    output logic [31:0] target
);

    logic [31:0] seq_pc;
    logic        unused_opcode;

    assign seq_pc        = ex_pc + 32'(INSTR_BYTES);
    assign unused_opcode = ^ex_instr[31:26];

    assign take   = ex_valid & (jump_sel | (branch_sel & zero));
    assign target = jump_sel ? {seq_pc[31:28], ex_instr[25:0], 2'b00}
                             : seq_pc + branch_offset(ex_instr[15:0]);

endmodule

// File: rtl/fetch_sequencer.sv
// Single-outstanding instruction fetch controller with decode buffer and redirect handling.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_instr,
    input  logic        branch_sel,
    input  logic        zero,
    input  logic        jump_sel,
    output logic        redirect
);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc, pc_nxt;
    logic [31:0]  req_pc, req_pc_nxt;
    logic         buf_load, buf_clear;
    logic         take;
    logic [31:0]  target;

    next_pc_calc u_next_pc_calc (
        .ex_pc      (ex_pc),
        .ex_instr   (ex_instr),
        .branch_sel (branch_sel),
        .zero       (zero),
        .jump_sel   (jump_sel),
        .ex_valid   (ex_valid),
        .take       (take),
        .target     (target)
    );

    assign imem_addr = pc;

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        req_pc_nxt = req_pc;
        imem_req   = 1'b0;
        buf_load   = 1'b0;
        buf_clear  = 1'b0;
        unique case (state)
            IDLE: begin
                state_nxt = REQ;
                if (take) pc_nxt = target;
            end
            REQ: begin
                imem_req = 1'b1;
                if (take) begin
                    pc_nxt = target;
                    if (imem_gnt) state_nxt = DROP;
                end else if (imem_gnt) begin
                    req_pc_nxt = pc;
                    pc_nxt     = pc + 32'(INSTR_BYTES);
                    state_nxt  = WAIT;
                end
            end
            WAIT: begin
                if (take) begin
                    pc_nxt    = target;
                    state_nxt = imem_rvalid ? REQ : DROP;
                end else if (imem_rvalid) begin
                    buf_load  = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (take) begin
                    buf_clear = 1'b1;
                    pc_nxt    = target;
                    state_nxt = REQ;
                end else if (id_ready) begin
                    buf_clear = 1'b1;
                    state_nxt = REQ;
                end
            end
            DROP: begin
                if (take) pc_nxt = target;
                // The stale response retires the old request even if a new redirect lands with it.
                if (imem_rvalid) state_nxt = REQ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            req_pc   <= '0;
            redirect <= 1'b0;
            if_valid <= 1'b0;
            if_instr <= '0;
            if_pc    <= '0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            req_pc   <= req_pc_nxt;
            redirect <= take;
            if (buf_load) begin
                if_valid <= 1'b1;
                if_instr <= imem_rdata;
                if_pc    <= req_pc;
            end else if (buf_clear) begin
                if_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer with a delivery scoreboard.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_instr;
    logic        branch_sel;
    logic        zero;
    logic        jump_sel;
    logic        redirect;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .id_ready    (id_ready),
        .ex_valid    (ex_valid),
        .ex_pc       (ex_pc),
        .ex_instr    (ex_instr),
        .branch_sel  (branch_sel),
        .zero        (zero),
        .jump_sel    (jump_sel),
        .redirect    (redirect)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] addr);
        return ~addr ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_ex();
        ex_valid   = 1'b0;
        branch_sel = 1'b0;
        zero       = 1'b0;
        jump_sel   = 1'b0;
        ex_pc      = '0;
        ex_instr   = '0;
    endtask

    task automatic wait_req(input logic [31:0] exp_addr);
        bit found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req === 1'b1) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("req_seen", 32'(found), 32'd1);
        if (found) chk("req_addr", imem_addr, exp_addr);
    endtask

    task automatic issue_and_fill(input logic [31:0] addr);
        exp_t e;
        wait_req(addr);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        chk("wait_no_req", 32'(imem_req), 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = instr_of(addr);
        exp_q.push_back(exp_t'{pc: addr, instr: instr_of(addr)});
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        chk("buf_valid", 32'(if_valid), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("if_pc", if_pc, e.pc);
            chk("if_instr", if_instr, e.instr);
        end
    endtask

    task automatic release_buf();
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        chk("buf_cleared", 32'(if_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] held_pc, held_instr;

        rst_n       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        id_ready    = 1'b0;
        clear_ex();

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_instr", if_instr, 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_redirect", 32'(redirect), 32'd0);
        rst_n = 1'b1;
        chk("idle_no_req", 32'(imem_req), 32'd0);
        tick();
        chk("first_req", 32'(imem_req), 32'd1);

        // Sequential fetches
        issue_and_fill(32'h0); release_buf();
        issue_and_fill(32'h4); release_buf();
        issue_and_fill(32'h8); release_buf();

        // Decode stall in HOLD; a non-valid jump must not redirect
        issue_and_fill(32'hC);
        held_pc    = if_pc;
        held_instr = if_instr;
        jump_sel   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", 32'(if_valid), 32'd1);
            chk("stall_pc", if_pc, held_pc);
            chk("stall_instr", if_instr, held_instr);
            chk("stall_no_req", 32'(imem_req), 32'd0);
            chk("stall_no_redirect", 32'(redirect), 32'd0);
        end
        clear_ex();
        release_buf();

        // Taken branch while waiting for data: target 0x104 + (-1 << 2) = 0x100
        wait_req(32'h10);
        imem_gnt = 1'b1;
        tick();
        imem_gnt   = 1'b0;
        ex_valid   = 1'b1;
        branch_sel = 1'b1;
        zero       = 1'b1;
        ex_pc      = 32'h0000_0100;
        ex_instr   = 32'h1000_FFFF;
        tick();
        clear_ex();
        chk("br_redirect", 32'(redirect), 32'd1);
        chk("br_drop_no_req", 32'(imem_req), 32'd0);
        chk("br_no_valid", 32'(if_valid), 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        chk("br_redirect_pulse", 32'(redirect), 32'd0);
        chk("br_stale_dropped", 32'(if_valid), 32'd0);
        issue_and_fill(32'h100); release_buf();

        // Jump together with gnt in REQ: target {1, 0x40, 00} = 0x1000_0100
        wait_req(32'h104);
        imem_gnt = 1'b1;
        ex_valid = 1'b1;
        jump_sel = 1'b1;
        ex_pc    = 32'h1000_0000;
        ex_instr = 32'h0800_0040;
        tick();
        imem_gnt = 1'b0;
        clear_ex();
        chk("jmp_redirect", 32'(redirect), 32'd1);
        chk("jmp_drop_no_req", 32'(imem_req), 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        tick();
        imem_rvalid = 1'b0;
        chk("jmp_stale_dropped", 32'(if_valid), 32'd0);
        issue_and_fill(32'h1000_0100); release_buf();

        // Jump without gnt retargets the pending request to 0xFFFF_FFFC, then wraps
        wait_req(32'h1000_0104);
        ex_valid = 1'b1;
        jump_sel = 1'b1;
        ex_pc    = 32'hF000_0000;
        ex_instr = 32'h0BFF_FFFF;
        tick();
        clear_ex();
        chk("retarget_redirect", 32'(redirect), 32'd1);
        chk("retarget_req", 32'(imem_req), 32'd1);
        chk("retarget_addr", imem_addr, 32'hFFFF_FFFC);
        issue_and_fill(32'hFFFF_FFFC); release_buf();
        wait_req(32'h0);

        // Reset asserted during WAIT
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        chk("pre_rst_addr", imem_addr, 32'h4);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", 32'(imem_req), 32'd0);
        chk("mid_rst_addr", imem_addr, 32'h0);
        chk("mid_rst_if_pc", if_pc, 32'h0);
        chk("mid_rst_if_instr", if_instr, 32'h0);
        chk("mid_rst_redirect", 32'(redirect), 32'd0);
        @(negedge clk);
        rst_n       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h5555_AAAA;
        tick();
        imem_rvalid = 1'b0;
        chk("late_rvalid_ignored", 32'(if_valid), 32'd0);
        chk("post_rst_req", 32'(imem_req), 32'd1);
        chk("post_rst_addr", imem_addr, 32'h0);
        issue_and_fill(32'h0); release_buf();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
